// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants, typedefs and parameter-legality helper for sync_fifo_flex.
// Default geometry matches the fixed 32-entry FIFO this block replaces.
package fifo_param_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

  typedef logic [DEF_PTR_W-1:0] fifo_ptr_t;
  typedef logic [DEF_PTR_W:0]   fifo_count_t;

  // True when the geometry and thresholds describe a usable FIFO.
  function automatic bit thresh_ok(input int data_w, input int depth,
                                   input int af, input int ae);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (data_w >= 1) && (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bus of sync_fifo_flex; master = user side, slave = FIFO.
interface sync_fifo_flex_if #(
  parameter int DATA_W = fifo_param_pkg::DEF_DATA_W,
  parameter int DEPTH  = fifo_param_pkg::DEF_DEPTH
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  logic                     clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Contents are never reset; the control logic tracks what is valid.
module fifo_ram
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky
// error flags and optional first-word-fall-through read mode.
module sync_fifo_flex
  import fifo_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rstn,
  sync_fifo_flex_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!thresh_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_flex: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow, r_underflow;
  logic              w_empty, w_full, w_rd_acc, w_wr_acc;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_rd_acc = bus.rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      // A fresh error in the clearing cycle takes priority over clr_err.
      r_overflow  <= (bus.wr_en && !w_wr_acc) || (r_overflow && !bus.clr_err);
      r_underflow <= (bus.rd_en && !w_rd_acc) || (r_underflow && !bus.clr_err);
    end
  end

  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = w_ram_rdata;
    assign bus.rd_valid = !w_empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_ram_rdata;
      end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
  end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read 32-deep instance and an FWFT
// 8-deep instance, checked each cycle against queue models plus literal checks.
module tb_sync_fifo_flex;
  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  sync_fifo_flex_if #(.DATA_W(8), .DEPTH(32)) b0 ();
  sync_fifo_flex_if #(.DATA_W(8), .DEPTH(8))  b1 ();

  sync_fifo_flex #(.DATA_W(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0))
    u_dut0 (.clk(clk), .rstn(rstn), .bus(b0));
  sync_fifo_flex #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
    u_dut1 (.clk(clk), .rstn(rstn), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: plain queues and sticky bits.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m0_data  = '0;
  bit         m0_valid = 0;
  bit         m0_ovf = 0, m0_unf = 0, m1_ovf = 0, m1_unf = 0;
  bit         r0_ok, w0_ok, r1_ok, w1_ok;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q0.delete();
      q1.delete();
      m0_data = '0;
      m0_valid = 0;
      m0_ovf = 0; m0_unf = 0; m1_ovf = 0; m1_unf = 0;
    end else begin
      r0_ok = b0.rd_en && (q0.size() > 0);
      w0_ok = b0.wr_en && ((q0.size() < 32) || r0_ok);
      m0_ovf = (b0.wr_en && !w0_ok) || (m0_ovf && !b0.clr_err);
      m0_unf = (b0.rd_en && !r0_ok) || (m0_unf && !b0.clr_err);
      m0_valid = r0_ok;
      if (r0_ok) m0_data = q0.pop_front();
      if (w0_ok) q0.push_back(b0.wr_data);

      r1_ok = b1.rd_en && (q1.size() > 0);
      w1_ok = b1.wr_en && ((q1.size() < 8) || r1_ok);
      m1_ovf = (b1.wr_en && !w1_ok) || (m1_ovf && !b1.clr_err);
      m1_unf = (b1.rd_en && !r1_ok) || (m1_unf && !b1.clr_err);
      if (r1_ok) void'(q1.pop_front());
      if (w1_ok) q1.push_back(b1.wr_data);
    end
  end

  always @(negedge clk) begin
    chk("d0_count",  b0.count,        q0.size());
    chk("d0_empty",  b0.empty,        q0.size() == 0);
    chk("d0_full",   b0.full,         q0.size() == 32);
    chk("d0_afull",  b0.almost_full,  q0.size() >= 28);
    chk("d0_aempty", b0.almost_empty, q0.size() <= 4);
    chk("d0_rvalid", b0.rd_valid,     m0_valid);
    chk("d0_rdata",  b0.rd_data,      m0_data);
    chk("d0_ovf",    b0.overflow,     m0_ovf);
    chk("d0_unf",    b0.underflow,    m0_unf);
    chk("d1_count",  b1.count,        q1.size());
    chk("d1_full",   b1.full,         q1.size() == 8);
    chk("d1_afull",  b1.almost_full,  q1.size() >= 6);
    chk("d1_aempty", b1.almost_empty, q1.size() <= 2);
    chk("d1_rvalid", b1.rd_valid,     q1.size() > 0);
    chk("d1_ovf",    b1.overflow,     m1_ovf);
    chk("d1_unf",    b1.underflow,    m1_unf);
    if (q1.size() > 0) chk("d1_head", b1.rd_data, q1[0]);
  end

  task automatic step0(input bit w, input int d, input bit r, input bit c);
    b0.wr_en = w; b0.wr_data = 8'(d); b0.rd_en = r; b0.clr_err = c;
    @(posedge clk); #1;
    b0.wr_en = 0; b0.rd_en = 0; b0.clr_err = 0;
  endtask

  task automatic step1(input bit w, input int d, input bit r);
    b1.wr_en = w; b1.wr_data = 8'(d); b1.rd_en = r; b1.clr_err = 0;
    @(posedge clk); #1;
    b1.wr_en = 0; b1.rd_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    b0.wr_en = 0; b0.wr_data = '0; b0.rd_en = 0; b0.clr_err = 0;
    b1.wr_en = 0; b1.wr_data = '0; b1.rd_en = 0; b1.clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", b0.count, 0);
    chk("rst_empty", b0.empty, 1);
    chk("rst_aempty", b0.almost_empty, 1);
    chk("rst_afull", b0.almost_full, 0);
    chk("rst_rdata", b0.rd_data, 0);
    chk("rst_rvalid1", b1.rd_valid, 0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    // Fill 1..32, then one rejected write.
    for (int i = 1; i <= 32; i++) begin
      step0(1, i, 0, 0);
      chk("fill_afull", b0.almost_full, i >= 28);
      chk("fill_full", b0.full, i == 32);
    end
    chk("fill_count", b0.count, 32);
    step0(1, 99, 0, 0);
    chk("ovf_count", b0.count, 32);
    chk("ovf_set", b0.overflow, 1);

    step0(1, 77, 0, 1);
    chk("clr_vs_ovf", b0.overflow, 1);
    step0(0, 0, 0, 1);
    chk("clr_alone", b0.overflow, 0);

    // Full with simultaneous read/write: 1 leaves, 33 enters behind 2..32.
    step0(1, 33, 1, 0);
    chk("fullrw_count", b0.count, 32);
    chk("fullrw_data", b0.rd_data, 1);
    chk("fullrw_valid", b0.rd_valid, 1);

    for (int i = 0; i < 33; i++) begin
      step0(0, 0, 1, 0);
      if (i < 32) begin
        chk("drain_data", b0.rd_data, i + 2);
        chk("drain_valid", b0.rd_valid, 1);
      end else begin
        chk("drain_unf", b0.underflow, 1);
        chk("drain_valid_end", b0.rd_valid, 0);
        chk("drain_empty", b0.empty, 1);
        chk("drain_count", b0.count, 0);
      end
    end

    step0(0, 0, 0, 1);
    chk("unf_clr", b0.underflow, 0);
    step0(1, 55, 1, 0);
    chk("emptyrw_count", b0.count, 1);
    chk("emptyrw_unf", b0.underflow, 1);
    chk("emptyrw_valid", b0.rd_valid, 0);
    step0(0, 0, 1, 0);
    chk("emptyrw_data", b0.rd_data, 55);
    chk("emptyrw_valid2", b0.rd_valid, 1);
    step0(0, 0, 0, 1);

    // FWFT instance: occupancy held at 3 while 20 words stream through.
    for (int i = 0; i < 3; i++) step1(1, 100 + i, 0);
    chk("fwft_head0", b1.rd_data, 100);
    chk("fwft_valid0", b1.rd_valid, 1);
    for (int k = 0; k < 17; k++) begin
      step1(1, 103 + k, 1);
      chk("fwft_head", b1.rd_data, 101 + k);
      chk("fwft_count", b1.count, 3);
    end
    for (int k = 0; k < 3; k++) step1(0, 0, 1);
    chk("fwft_valid_end", b1.rd_valid, 0);

    // Reset mid-burst with count = 5 and underflow set.
    step0(0, 0, 1, 0);
    chk("pre_rst_unf", b0.underflow, 1);
    for (int i = 0; i < 5; i++) step0(1, 200 + i, 0, 0);
    for (int i = 0; i < 2; i++) step1(1, 50 + i, 0);
    chk("pre_rst_count", b0.count, 5);
    b0.wr_en = 1; b0.wr_data = 8'd6;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_count", b0.count, 0);
    chk("mid_rst_empty", b0.empty, 1);
    chk("mid_rst_aempty", b0.almost_empty, 1);
    chk("mid_rst_unf", b0.underflow, 0);
    chk("mid_rst_rdata", b0.rd_data, 0);
    chk("mid_rst_count1", b1.count, 0);
    chk("mid_rst_valid1", b1.rd_valid, 0);
    b0.wr_en = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_count", b0.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
